input_interface: RTL and testbench
==================================

INPUT_INTERFACE -- requirements
Module: input_interface

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable cycles needed to accept an input change (20 ms at 50 MHz).
REQ-002 SHALL have parameter NUM_TRACKS, default 4, fixed at 4 for this revision.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port KEY, input, 3 bits: raw active-low DE-series pushbuttons KEY[3:1]. Bit 0 toggles the step, bit 1 moves the cursor right, bit 2 moves the cursor left.
REQ-007 SHALL have port SW, input, 10 bits: raw slide switches. SW[1:0] selects the track, SW[9] is the clear-track request, and all other bits are ignored.
REQ-008 SHALL have port pattern, output, 64 bits: step pattern, where bit track*16+step means the step is active.
REQ-009 SHALL have port cursor, output, 4 bits: currently selected step, 0-15.
REQ-010 SHALL have port track, output, 2 bits: currently selected track.
REQ-011 SHALL have port edit_pulse, output, 1 bit: high for exactly one cycle per cycle in which pattern changes.

Function
REQ-012 SHALL pass each of KEY[2:0], SW[9], SW[1:0] through a two-flop synchronizer before any use.
REQ-013 SHALL debounce KEY[2:0] and SW[9] independently:
- per-input counter; stable level flips only after the synchronized level differs from it on DEBOUNCE_CYCLES consecutive edges;
- any cycle of agreement clears that counter.
REQ-014 SHALL generate one press event per key when its debounced level falls 1->0. Releases, and holding a key, generate no further events (no auto-repeat).
REQ-015 SHALL generate one clear event when debounced SW[9] rises 0->1. Falling edges are ignored.
REQ-016 SHALL drive track from synchronized SW[1:0] without debounce, a two-cycle latency.
REQ-017 SHALL apply end-to-end latency of exactly DEBOUNCE_CYCLES+3 rising edges for key and clear events. Counting starts at the first edge that samples the new raw level; outputs update on that final edge.
REQ-018 SHALL, on a toggle event, invert pattern bit track*16+cursor, using the track and cursor values held in that cycle.
REQ-019 SHALL, on a right event, set cursor to (cursor+1) mod 16, so 15 wraps to 0.
REQ-020 SHALL, on a left event, set cursor to (cursor-1) mod 16, so 0 wraps to 15.
REQ-021 SHALL, when left and right events occur in the same cycle, leave cursor unchanged.
REQ-022 SHALL, when toggle and a move occur in the same cycle, apply the toggle at the pre-move cursor and the move in the same edge.
REQ-023 SHALL, on a clear event, zero the 16 bits of the current track. Clear overrides a same-cycle toggle; a same-cycle move still applies.
REQ-024 SHALL assert edit_pulse on the edge where pattern takes a new value. It SHALL NOT be asserted for cursor- or track-only changes, or for a clear of an already-empty track.
REQ-025 SHALL leave other tracks' bits unchanged by any edit.

Reset
REQ-026 SHALL, while resetn is low, asynchronously force pattern=0, cursor=0, edit_pulse=0 and all debounce counters to 0.
REQ-027 SHALL, while resetn is low, force all synchronizer and debounced states to released: 1 for keys, 0 for SW[9].
REQ-028 SHALL, while resetn is low, force track=0 until the synchronizer refills after reset.
REQ-029 SHALL, after reset is released, generate exactly one event for a key held through reset, with the normal REQ-017 latency.
REQ-030 SHALL discard any in-progress debounce count when reset is asserted mid-operation.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 SHALL cover: reset, SW=0, KEY[0] low and held 20 cycles -> at edge 7 pattern[0]=1 with edit_pulse high for one cycle, then no further change.
REQ-032 SHALL cover: KEY[1] low for 3 cycles, high for 1, low for 3 cycles -> no cursor change, since bounce is rejected.
REQ-033 SHALL cover: cursor=15, one KEY[1] press -> cursor=0; then one KEY[2] press -> cursor=15.
REQ-034 SHALL cover: SW[1:0]=2, cursor=5, toggle -> pattern[37]=1; then SW[9] raised -> bits 47:32 = 0 and edit_pulse for one cycle, with tracks 0, 1, 3 unchanged.
REQ-035 SHALL cover: KEY[0] and KEY[1] pressed on the same edge at cursor=3 -> pattern[3] toggles and cursor=4 on the same edge. KEY[1] and KEY[2] together -> cursor unchanged.
REQ-036 SHALL cover: resetn pulsed low mid-debounce with KEY[0] held -> outputs zero during reset, then exactly one toggle DEBOUNCE_CYCLES+3 edges after release.

Source files
------------

// File: rtl/input_interface.sv
// rtl/input_interface.sv - step-sequencer front panel: synchronized, debounced keys/switches driving a 4x16 pattern editor
module input_interface #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_TRACKS      = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic [2:0]                 KEY,
  input  logic [9:0]                 SW,
  output logic [16*NUM_TRACKS-1:0]   pattern,
  output logic [3:0]                 cursor,
  output logic [1:0]                 track,
  output logic                       edit_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Released levels: keys idle high, clear switch idle low.
  localparam logic [3:0] REL_LVL = 4'b0111;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    stable;
  logic [3:0]    stable_d;
  logic [CW-1:0] count [4];
  logic [1:0]    trk_s1;

  logic          toggle_ev;
  logic          right_ev;
  logic          left_ev;
  logic          clear_ev;

  logic [16*NUM_TRACKS-1:0] pattern_next;
  logic [3:0]               cursor_next;

  logic unused_sw;
  assign unused_sw = ^SW[8:2];

  assign raw = {SW[9], KEY};

  // Events come from the registered debounced level, adding the final edge of latency.
  assign toggle_ev = stable_d[0] & ~stable[0];
  assign right_ev  = stable_d[1] & ~stable[1];
  assign left_ev   = stable_d[2] & ~stable[2];
  assign clear_ev  = ~stable_d[3] & stable[3];

  always_comb begin
    pattern_next = pattern;
    cursor_next  = cursor;
    if (clear_ev) begin
      pattern_next[{track, 4'b0000} +: 16] = 16'h0000;
    end else if (toggle_ev) begin
      pattern_next[{track, cursor}] = ~pattern[{track, cursor}];
    end
    case ({left_ev, right_ev})
      2'b01:   cursor_next = cursor + 4'd1;
      2'b10:   cursor_next = cursor - 4'd1;
      default: cursor_next = cursor;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1      <= REL_LVL;
      sync2      <= REL_LVL;
      stable     <= REL_LVL;
      stable_d   <= REL_LVL;
      for (int i = 0; i < 4; i++) count[i] <= '0;
      trk_s1     <= 2'b00;
      track      <= 2'b00;
      pattern    <= '0;
      cursor     <= 4'd0;
      edit_pulse <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == LAST) begin
          count[i]  <= '0;
          stable[i] <= sync2[i];
        end else begin
          count[i] <= count[i] + 1'b1;
        end
      end
      trk_s1     <= SW[1:0];
      track      <= trk_s1;
      pattern    <= pattern_next;
      cursor     <= cursor_next;
      edit_pulse <= (pattern_next != pattern);
    end
  end

endmodule

// File: tb/tb_input_interface.sv
// tb/tb_input_interface.sv - directed vector bench for input_interface with DEBOUNCE_CYCLES=4
module tb_input_interface;

  localparam logic [2:0] K_IDLE  = 3'b111;
  localparam logic [2:0] K_TOG   = 3'b110;
  localparam logic [2:0] K_RIGHT = 3'b101;
  localparam logic [2:0] K_LEFT  = 3'b011;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  KEY = K_IDLE;
  logic [9:0]  SW = 10'h000;
  logic [63:0] pattern;
  logic [3:0]  cursor;
  logic [1:0]  track;
  logic        edit_pulse;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  key;
    logic [9:0]  sw;
    logic [63:0] p;
    logic [3:0]  c;
    logic [1:0]  t;
  } vec_t;

  vec_t vecs[$];

  input_interface #(.DEBOUNCE_CYCLES(4), .NUM_TRACKS(4)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .KEY       (KEY),
    .SW        (SW),
    .pattern   (pattern),
    .cursor    (cursor),
    .track     (track),
    .edit_pulse(edit_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] k, input logic [9:0] s, input logic [63:0] p,
                     input logic [3:0] c, input logic [1:0] t);
    vec_t v;
    v.key = k; v.sw = s; v.p = p; v.c = c; v.t = t;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive(input logic [2:0] k, input logic [9:0] s, input int n);
    @(negedge clk);
    KEY = k;
    SW  = s;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int bad;
    int ed;
    logic [63:0] p;

    // Table: starts from reset state (pattern 0, cursor 0, track 0).
    add(K_IDLE,  10'h000, 64'h0, 0, 0);
    add(K_TOG,   10'h000, 64'h1, 0, 0);
    add(K_IDLE,  10'h000, 64'h1, 0, 0);
    add(K_RIGHT, 10'h000, 64'h1, 1, 0);
    add(K_IDLE,  10'h000, 64'h1, 1, 0);
    add(K_TOG,   10'h000, 64'h3, 1, 0);
    add(K_IDLE,  10'h000, 64'h3, 1, 0);
    add(K_LEFT,  10'h000, 64'h3, 0, 0);
    add(K_IDLE,  10'h000, 64'h3, 0, 0);
    add(K_LEFT,  10'h000, 64'h3, 15, 0);
    add(K_IDLE,  10'h000, 64'h3, 15, 0);
    add(K_RIGHT, 10'h000, 64'h3, 0, 0);
    add(K_IDLE,  10'h000, 64'h3, 0, 0);
    add(K_LEFT,  10'h000, 64'h3, 15, 0);
    add(K_IDLE,  10'h001, 64'h3, 15, 1);
    add(K_TOG,   10'h001, 64'h0000_0000_8000_0003, 15, 1);
    add(K_IDLE,  10'h003, 64'h0000_0000_8000_0003, 15, 3);
    add(K_TOG,   10'h003, 64'h8000_0000_8000_0003, 15, 3);
    add(K_IDLE,  10'h002, 64'h8000_0000_8000_0003, 15, 2);
    for (int k = 0; k < 6; k++) begin
      add(K_RIGHT, 10'h002, 64'h8000_0000_8000_0003, 4'(k), 2);
      add(K_IDLE,  10'h002, 64'h8000_0000_8000_0003, 4'(k), 2);
    end
    add(K_TOG,   10'h002, 64'h8000_0020_8000_0003, 5, 2);
    add(K_IDLE,  10'h002, 64'h8000_0020_8000_0003, 5, 2);
    add(K_IDLE,  10'h202, 64'h8000_0000_8000_0003, 5, 2);
    add(K_IDLE,  10'h002, 64'h8000_0000_8000_0003, 5, 2);
    add(K_LEFT,  10'h002, 64'h8000_0000_8000_0003, 4, 2);
    add(K_IDLE,  10'h002, 64'h8000_0000_8000_0003, 4, 2);
    add(K_LEFT,  10'h002, 64'h8000_0000_8000_0003, 3, 2);
    add(K_IDLE,  10'h000, 64'h8000_0000_8000_0003, 3, 0);
    add(3'b100,  10'h000, 64'h8000_0000_8000_000B, 4, 0);
    add(K_IDLE,  10'h000, 64'h8000_0000_8000_000B, 4, 0);
    add(3'b001,  10'h000, 64'h8000_0000_8000_000B, 4, 0);
    add(K_IDLE,  10'h000, 64'h8000_0000_8000_000B, 4, 0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_pattern", pattern, 64'h0);
    check("reset_cursor", 64'(cursor), 64'h0);
    check("reset_edit", 64'(edit_pulse), 64'h0);
    resetn = 1'b1;

    // Exact latency of a single press held for 20 cycles.
    @(negedge clk);
    KEY = K_TOG;
    bad = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (pattern != 64'h0 || edit_pulse) bad++;
    end
    check("latency_pre_edge7", 64'(bad), 64'h0);
    tick();
    check("latency_edge7_pattern", pattern, 64'h1);
    check("latency_edge7_edit", 64'(edit_pulse), 64'h1);
    tick();
    check("latency_edge8_edit", 64'(edit_pulse), 64'h0);
    ed = 0;
    for (int e = 9; e <= 20; e++) begin
      tick();
      ed += int'(edit_pulse);
    end
    check("hold_no_repeat_edits", 64'(ed), 64'h0);
    check("hold_pattern", pattern, 64'h1);
    drive(K_IDLE, 10'h000, HOLD);
    check("release_pattern", pattern, 64'h1);

    // Bounce: 3 low, 1 high, 3 low never reaches 4 stable cycles.
    drive(K_RIGHT, 10'h000, 3);
    drive(K_IDLE,  10'h000, 1);
    drive(K_RIGHT, 10'h000, 3);
    drive(K_IDLE,  10'h000, HOLD);
    check("bounce_cursor", 64'(cursor), 64'h0);

    // Track follows SW[1:0] after two edges.
    @(negedge clk);
    SW = 10'h003;
    tick();
    check("track_edge1", 64'(track), 64'h0);
    tick();
    check("track_edge2", 64'(track), 64'h3);
    @(negedge clk);
    SW = 10'h000;

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      KEY = vecs[i].key;
      SW  = vecs[i].sw;
      repeat (HOLD) @(posedge clk);
      #1;
      check($sformatf("vec%0d_pattern", i), pattern, vecs[i].p);
      check($sformatf("vec%0d_cursor", i), 64'(cursor), 64'(vecs[i].c));
      check($sformatf("vec%0d_track", i), 64'(track), 64'(vecs[i].t));
    end

    // Clear of a populated track: one edit pulse; falling switch and empty clear: none.
    p = pattern;
    p[15:0] = 16'h0000;
    @(negedge clk);
    SW = 10'h200;
    ed = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      ed += int'(edit_pulse);
    end
    check("clear_edit_count", 64'(ed), 64'h1);
    check("clear_pattern", pattern, p);
    @(negedge clk);
    SW = 10'h000;
    ed = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      ed += int'(edit_pulse);
    end
    @(negedge clk);
    SW = 10'h200;
    for (int e = 0; e < 12; e++) begin
      tick();
      ed += int'(edit_pulse);
    end
    check("clear_empty_edits", 64'(ed), 64'h0);
    check("clear_empty_pattern", pattern, p);
    drive(K_IDLE, 10'h000, HOLD);

    // Reset mid-debounce with toggle held through reset.
    @(negedge clk);
    KEY = K_TOG;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_pattern", pattern, 64'h0);
    check("midreset_cursor", 64'(cursor), 64'h0);
    check("midreset_edit", 64'(edit_pulse), 64'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (pattern != 64'h0 || edit_pulse) bad++;
    end
    check("postreset_pre_edge7", 64'(bad), 64'h0);
    tick();
    check("postreset_edge7_pattern", pattern, 64'h1);
    check("postreset_edge7_edit", 64'(edit_pulse), 64'h1);
    ed = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      ed += int'(edit_pulse);
    end
    check("postreset_single_toggle", 64'(ed), 64'h0);
    check("postreset_pattern_final", pattern, 64'h1);
    @(negedge clk);
    KEY = K_IDLE;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
